// File: rtl/uart_echo_responder.sv
// uart_echo_responder: 8N1 far-end UART peer. Receives bytes on rx,
// queues them in a small FIFO and re-sends each (XOR-masked) on tx.
//
// Ports:
//   clk, rst_n      single clock, async active-low reset
//   rx              serial in (idle high, asynchronous to clk)
//   tx_hold         1 = do not start a new TX frame
//   tx, tx_busy     serial out (idle high), frame-in-progress flag
//   rx_byte         last good received byte (unmasked)
//   rx_valid        1-cycle pulse on every good stop bit
//   frame_err       1-cycle pulse when the stop bit is sampled low
//   overflow        1-cycle pulse when a good byte is dropped (FIFO full)
//   fifo_count      entries currently queued
module uart_echo_responder #(
  parameter int unsigned CLK_PER_BIT = 10,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  XOR_MASK    = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  input  logic                         tx_hold,
  output logic                         tx,
  output logic                         tx_busy,
  output logic [7:0]                   rx_byte,
  output logic                         rx_valid,
  output logic                         frame_err,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_PER_BIT);

  localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT1     = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_st_e;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_st_e;

  // ---------------- synchroniser ----------------
  logic s1_q, s2_q, rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
    end
  end

  assign rxs = s2_q;

  // ---------------- shared FIFO control ----------------
  rx_st_e        rx_st_q;
  tx_st_e        tx_st_q;
  logic [CW-1:0] rx_cnt_q, tx_cnt_q;
  logic [7:0]    rx_sh_q, tx_sh_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [7:0]    mem [FIFO_DEPTH];

  logic rx_tick, tx_tick;
  logic push_req_d, push_d, pop_d, full_d;

  assign rx_tick    = (rx_cnt_q == BIT_END);
  assign tx_tick    = (tx_cnt_q == BIT_END);
  assign full_d     = (cnt_q == DEPTH_C);
  assign push_req_d = (rx_st_q == R_STOP) && rx_tick && rxs;
  assign pop_d      = (tx_st_q == T_IDLE) && (cnt_q != '0)
                      && !tx_hold;
  // A full FIFO still accepts when the same cycle frees a slot.
  assign push_d     = push_req_d && (!full_d || pop_d);

  // ---------------- RX FSM ----------------
  logic [2:0] rx_bit_q;
  logic [7:0] rx_byte_q;
  logic       rx_valid_q, frame_err_q, overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q     <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      unique case (rx_st_q)
        R_IDLE: begin
          if (!rxs) begin
            rx_st_q  <= R_START;
            rx_cnt_q <= '0;
          end
        end
        R_START: begin
          // Mid-start-bit recheck rejects short glitches.
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rxs ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        R_DATA: begin
          if (rx_tick) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rxs, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        R_STOP: begin
          if (rx_tick) begin
            rx_cnt_q <= '0;
            if (rxs) begin
              rx_byte_q  <= rx_sh_q;
              rx_valid_q <= 1'b1;
              overflow_q <= full_d && !pop_d;
              rx_st_q    <= R_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_st_q     <= R_WAIT;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        R_WAIT: begin
          if (rxs) rx_st_q <= R_IDLE;
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push_d) mem[wr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_d) wr_q <= wr_q + PTR_ONE;
      if (pop_d)  rd_q <= rd_q + PTR_ONE;
      unique case ({push_d, pop_d})
        2'b10:   cnt_q <= cnt_q + CNT1;
        2'b01:   cnt_q <= cnt_q - CNT1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0] tx_bit_q;
  logic       tx_q, tx_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= T_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      unique case (tx_st_q)
        T_IDLE: begin
          if (pop_d) begin
            tx_sh_q   <= mem[rd_q] ^ XOR_MASK;
            tx_q      <= 1'b0;
            tx_busy_q <= 1'b1;
            tx_cnt_q  <= '0;
            tx_st_q   <= T_START;
          end
        end
        T_START: begin
          if (tx_tick) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_q     <= tx_sh_q[0];
            tx_st_q  <= T_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        T_DATA: begin
          if (tx_tick) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              tx_st_q <= T_STOP;
            end else begin
              tx_q     <= tx_sh_q[1];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        T_STOP: begin
          if (tx_tick) begin
            tx_cnt_q  <= '0;
            tx_busy_q <= 1'b0;
            tx_st_q   <= T_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        default: tx_st_q <= T_IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = tx_busy_q;
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: directed bench for uart_echo_responder.
// Plain echo on dut1, XOR_MASK=8'hFF echo on dut2, shared rx.
module tb_uart_echo_responder;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx_hold = 1'b0;
  logic       tx1, busy1, rv1, fe1, ov1;
  logic       tx2, busy2, rv2, fe2, ov2;
  logic [7:0] rxb1, rxb2;
  logic [2:0] fc1, fc2;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int txlow_cnt = 0;

  always #10 clk = ~clk;

  uart_echo_responder #(
    .CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .XOR_MASK(8'h00)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx_hold(tx_hold),
    .tx(tx1), .tx_busy(busy1), .rx_byte(rxb1),
    .rx_valid(rv1), .frame_err(fe1), .overflow(ov1),
    .fifo_count(fc1)
  );

  uart_echo_responder #(
    .CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .XOR_MASK(8'hFF)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx_hold(tx_hold),
    .tx(tx2), .tx_busy(busy2), .rx_byte(rxb2),
    .rx_valid(rv2), .frame_err(fe2), .overflow(ov2),
    .fifo_count(fc2)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (rv1 === 1'b1) rv_cnt++;
      if (fe1 === 1'b1) fe_cnt++;
      if (ov1 === 1'b1) ov_cnt++;
      if (tx1 !== 1'b1) txlow_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Records one tx frame: bits[0]=start .. bits[9]=stop,
  // taken mid-bit; glitch counts cycles off their bit value.
  task automatic get_frame(input int sel, output logic [9:0] bits,
                           output int glitch, output int nbusy,
                           output bit to);
    logic s [100];
    logic t;
    int   n;
    bits = '0; glitch = 0; nbusy = 0; to = 1'b0; n = 0;
    @(negedge clk);
    t = (sel != 0) ? tx2 : tx1;
    while (t !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
      t = (sel != 0) ? tx2 : tx1;
    end
    if (t !== 1'b0) begin
      to = 1'b1;
      return;
    end
    for (int i = 0; i < 100; i++) begin
      s[i] = (sel != 0) ? tx2 : tx1;
      if (((sel != 0) ? busy2 : busy1) !== 1'b1) nbusy++;
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) bits[j] = s[j*10+5];
    for (int i = 0; i < 100; i++)
      if (s[i] !== bits[i/10]) glitch++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx1, busy1, rv1, fe1, ov1} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 10000",
               {tx1, busy1, rv1, fe1, ov1});
    end
    n_cmp++;
    if (rxb1 !== 8'h00 || fc1 !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got byte=%h cnt=%0d want 00/0",
               rxb1, fc1);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || fc1 !== 3'd0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got tx=%b busy=%b cnt=%0d",
               tx1, busy1, fc1);
    end
  endtask

  task automatic test_echo;
    logic [9:0] bits;
    int gl, nb, rv0;
    bit to;
    rv0 = rv_cnt;
    fork
      send_byte(8'hAB, 1'b1);
      get_frame(0, bits, gl, nb, to);
    join
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL echo_timeout: got no frame want frame");
    end
    n_cmp++;
    if (bits !== 10'b1101010110) begin
      n_bad++;
      $display("FAIL echo_bits: got %b want 1101010110", bits);
    end
    n_cmp++;
    if (gl !== 0 || nb !== 0) begin
      n_bad++;
      $display("FAIL echo_timing: got glitch=%0d nbusy=%0d want 0/0",
               gl, nb);
    end
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL echo_busy_end: got %b want 0", busy1);
    end
    n_cmp++;
    if (rv_cnt - rv0 !== 1 || rxb1 !== 8'hAB) begin
      n_bad++;
      $display("FAIL echo_rx: got pulses=%0d byte=%h want 1/ab",
               rv_cnt - rv0, rxb1);
    end
    n_cmp++;
    if (fc1 !== 3'd0) begin
      n_bad++;
      $display("FAIL echo_count: got %0d want 0", fc1);
    end
  endtask

  task automatic test_xor_mask;
    logic [9:0] bits;
    int gl, nb;
    bit to;
    repeat (20) @(negedge clk);
    fork
      send_byte(8'h3C, 1'b1);
      get_frame(1, bits, gl, nb, to);
    join
    n_cmp++;
    if (to || bits !== 10'b1110000110 || gl !== 0) begin
      n_bad++;
      $display("FAIL xor_frame: got %b to=%0d gl=%0d want 1110000110",
               bits, to, gl);
    end
    n_cmp++;
    if (rxb2 !== 8'h3C) begin
      n_bad++;
      $display("FAIL xor_rx_byte: got %h want 3c", rxb2);
    end
  endtask

  task automatic test_glitch;
    int rv0, fe0, tl0;
    repeat (20) @(negedge clk);
    rv0 = rv_cnt; fe0 = fe_cnt; tl0 = txlow_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (rv_cnt != rv0 || fe_cnt != fe0) begin
      n_bad++;
      $display("FAIL glitch_pulses: got rv=%0d fe=%0d want 0/0",
               rv_cnt - rv0, fe_cnt - fe0);
    end
    n_cmp++;
    if (txlow_cnt != tl0 || fc1 !== 3'd0) begin
      n_bad++;
      $display("FAIL glitch_tx: got txlow=%0d cnt=%0d want 0/0",
               txlow_cnt - tl0, fc1);
    end
  endtask

  task automatic test_frame_error;
    int rv0, fe0, tl0;
    rv0 = rv_cnt; fe0 = fe_cnt; tl0 = txlow_cnt;
    send_byte(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    n_cmp++;
    if (fe_cnt - fe0 !== 1) begin
      n_bad++;
      $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0);
    end
    n_cmp++;
    if (rv_cnt != rv0 || txlow_cnt != tl0 || fc1 !== 3'd0) begin
      n_bad++;
      $display("FAIL ferr_no_echo: got rv=%0d txlow=%0d cnt=%0d",
               rv_cnt - rv0, txlow_cnt - tl0, fc1);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_f [4];
    logic [9:0] bits;
    logic [7:0] b;
    int rv0, ov0, tl0, gl, nb;
    bit to;
    exp_f[0] = 10'b1000000010;
    exp_f[1] = 10'b1000000100;
    exp_f[2] = 10'b1000000110;
    exp_f[3] = 10'b1000001000;
    rv0 = rv_cnt; ov0 = ov_cnt; tl0 = txlow_cnt;
    tx_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      b = 8'(k);
      send_byte(b, 1'b1);
    end
    n_cmp++;
    if (fc1 !== 3'd4 || ov_cnt != ov0) begin
      n_bad++;
      $display("FAIL b2b_fill: got cnt=%0d ovf=%0d want 4/0",
               fc1, ov_cnt - ov0);
    end
    send_byte(8'h05, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fc1 !== 3'd4 || ov_cnt - ov0 !== 1) begin
      n_bad++;
      $display("FAIL b2b_overflow: got cnt=%0d ovf=%0d want 4/1",
               fc1, ov_cnt - ov0);
    end
    n_cmp++;
    if (rv_cnt - rv0 !== 5 || rxb1 !== 8'h05) begin
      n_bad++;
      $display("FAIL b2b_rx: got pulses=%0d byte=%h want 5/05",
               rv_cnt - rv0, rxb1);
    end
    n_cmp++;
    if (txlow_cnt != tl0) begin
      n_bad++;
      $display("FAIL b2b_hold: got %0d tx-low cycles want 0",
               txlow_cnt - tl0);
    end
    tx_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      get_frame(0, bits, gl, nb, to);
      n_cmp++;
      if (to || bits !== exp_f[k] || gl !== 0) begin
        n_bad++;
        $display("FAIL b2b_echo%0d: got %b to=%0d gl=%0d want %b",
                 k, bits, to, gl, exp_f[k]);
      end
    end
    n_cmp++;
    if (fc1 !== 3'd0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: got cnt=%0d busy=%b want 0/0",
               fc1, busy1);
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [9:0] bits;
    int gl, nb, n;
    bit to;
    repeat (150) @(negedge clk);
    fork
      send_byte(8'h00, 1'b1);
      begin
        n = 0;
        while (tx1 !== 1'b0 && n < 400) begin
          @(negedge clk);
          n++;
        end
        repeat (25) @(negedge clk);
        n_cmp++;
        if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
          n_bad++;
          $display("FAIL rst_pre: got tx=%b busy=%b want 0/1",
                   tx1, busy1);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || fc1 !== 3'd0) begin
          n_bad++;
          $display("FAIL rst_mid_tx: got tx=%b busy=%b cnt=%0d",
                   tx1, busy1, fc1);
        end
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    fork
      send_byte(8'h5A, 1'b1);
      get_frame(0, bits, gl, nb, to);
    join
    n_cmp++;
    if (to || bits !== 10'b1010110100 || gl !== 0 || nb !== 0) begin
      n_bad++;
      $display("FAIL rst_next_echo: got %b to=%0d gl=%0d nb=%0d",
               bits, to, gl, nb);
    end
    n_cmp++;
    if (rxb1 !== 8'h5A) begin
      n_bad++;
      $display("FAIL rst_next_rx: got %h want 5a", rxb1);
    end
  endtask

  initial begin
    test_reset;
    test_echo;
    test_xor_mask;
    test_glitch;
    test_frame_error;
    test_back_to_back;
    test_reset_mid_tx;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
